linescanner_capture_engine: RTL
===============================

# linescanner_capture_engine

Parametrised successor to the single-channel line-scanner capture unit. Sequences the sensor control strobes (load_pulse, rst_cvc, rst_cds, sample) for each line, waits on the ADC handshake (end_adc), then captures CHANNELS parallel lanes of DATA_WIDTH-bit pixels while lval is high. Emits a valid-qualified pixel stream with start/end-of-line markers, a line counter and error flags. Sits between the sensor pads and the frame-buffer writer.

## Interface
- DATA_WIDTH, 8, bits per lane
- CHANNELS, 1, parallel ADC lanes (1..4)
- LINE_PIXELS, 1024, expected pixel words per line (per lane), ≥2
- LOAD_CYCLES, 4, load_pulse high width
- RST_CVC_CYCLES, 8, rst_cvc high width
- RST_CDS_CYCLES, 8, rst_cds high width
- SAMPLE_CYCLES, 7, sample high width
- ADC_TIMEOUT, 255, max cycles waiting for end_adc
- pixel_clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  start new lines while high
- end_adc  in  1  ADC conversion done (level)
- lval  in  1  line valid from sensor
- data  in  CHANNELS*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- load_pulse, rst_cvc, rst_cds, sample  out  1 each  sensor strobes
- pixel_data  out  CHANNELS*DATA_WIDTH  registered pixel word
- pixel_captured  out  1  pixel_data valid this cycle
- line_start, line_end  out  1  qualify first/last captured word
- line_count  out  16  completed lines, wraps at 0xFFFF→0
- err_timeout, err_length  out  1  sticky until reset

## Operation
- States: IDLE, LOAD, RST_CVC, RST_CDS, SAMPLE, WAIT_ADC, WAIT_LVAL, READOUT.
- IDLE→LOAD when enable=1. LOAD, RST_CVC, RST_CDS, SAMPLE each hold their own strobe high for exactly its *_CYCLES parameter, then advance in that order; strobes are mutually exclusive.
- WAIT_ADC: →WAIT_LVAL when end_adc=1; if ADC_TIMEOUT cycles elapse first, set err_timeout and →IDLE.
- WAIT_LVAL: →READOUT on first cycle lval=1; that cycle's data is captured.
- READOUT: every cycle lval=1 registers data into pixel_data, pulses pixel_captured, increments pixel counter. line_start on pixel 0. line_end on pixel LINE_PIXELS-1 or on the last word before lval falls, whichever first.
- lval falls: if count≠LINE_PIXELS set err_length; increment line_count; →LOAD if enable else IDLE.
- Words beyond LINE_PIXELS are dropped (pixel_captured stays 0), err_length set.
- enable deasserted mid-line: current line finishes normally, then IDLE.
- Counter widths: pixel counter $clog2(LINE_PIXELS+1); strobe counter sized for largest *_CYCLES/ADC_TIMEOUT.

## Timing
- Reset: state IDLE; all strobes, pixel_captured, line_start, line_end, err_* = 0; pixel_data = 0; line_count = 0. Reset mid-line aborts immediately, no partial line counted.
- enable sampled high at edge n → load_pulse high from edge n+1.
- Capture latency: data/lval at edge n → pixel_data, pixel_captured at output after edge n (1 cycle).
- line_end and pixel_captured coincide on the same cycle; for a 1-word line line_start=line_end=1.
- line_count updates the cycle after lval is sampled low.
- end_adc high on the same edge as the timeout expiry: success wins.

## Configuration
- LINESCANNER_TEST_PATTERN_EN: when defined, captured lane k word = (pixel counter + k) truncated to DATA_WIDTH instead of data; strobes, handshakes and flags unchanged. When undefined, data is captured unmodified and no pattern logic exists.

## Structure
- Package linescanner_pkg: state enum type, line_count width constant (16), helper function for counter width.
- One sub-module natural: linescanner_strobe_timer (loadable down-counter with done flag) reused for all strobe widths and ADC timeout.

## Test plan
- Default params, enable=1, end_adc high 160 ns after rst_cds falls, lval high 1024 cycles with data=0xFF → load_pulse 4 cycles, 1024 pixel_captured of 0xFF, line_start on first, line_end on last, line_count=1, no errors.
- end_adc never asserted → err_timeout=1 exactly 255 cycles after WAIT_ADC entry, state IDLE, no pixels.
- lval high 1030 cycles → 1024 captured, line_end on 1024th, err_length=1; lval 1000 cycles → line_end on 1000th, err_length=1.
- CHANNELS=4, data=0x44332211 → pixel_data=0x44332211 each word, lane order preserved.
- Reset asserted at pixel 500 → all outputs zero next cycle, line_count=0; next line after release completes cleanly.
- With LINESCANNER_TEST_PATTERN_EN, CHANNELS=2 → words 0x0100, 0x0201, … wrapping lane values at 0xFF.

Source files
------------

// File: rtl/linescanner_pkg.sv
// Shared state encoding, line-counter width and counter-sizing helpers for the
// line-scanner capture engine.
package linescanner_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_RST_CVC   = 3'd2,
    S_RST_CDS   = 3'd3,
    S_SAMPLE    = 3'd4,
    S_WAIT_ADC  = 3'd5,
    S_WAIT_LVAL = 3'd6,
    S_READOUT   = 3'd7
  } ls_state_t;

  localparam int LINE_COUNT_W = 16;

  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/linescanner_capture_engine_strobe_timer.sv
// Loadable down-counter shared by every strobe width and the ADC timeout;
// o_done is high while the count sits at zero.
module linescanner_strobe_timer
  import linescanner_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != {WIDTH{1'b0}}) begin
      r_count <= r_count - WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == {WIDTH{1'b0}});

endmodule

// File: rtl/linescanner_capture_engine.sv
// Line-scanner capture engine: sensor strobe sequencing, ADC handshake and
// multi-lane pixel capture. Optional build macro: LINESCANNER_TEST_PATTERN_EN.
module linescanner_capture_engine
  import linescanner_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CHANNELS       = 1,
  parameter int LINE_PIXELS    = 1024,
  parameter int LOAD_CYCLES    = 4,
  parameter int RST_CVC_CYCLES = 8,
  parameter int RST_CDS_CYCLES = 8,
  parameter int SAMPLE_CYCLES  = 7,
  parameter int ADC_TIMEOUT    = 255
) (
  input  logic                           i_pixel_clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_end_adc,
  input  logic                           i_lval,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
  output logic                           o_load_pulse,
  output logic                           o_rst_cvc,
  output logic                           o_rst_cds,
  output logic                           o_sample,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_pixel_data,
  output logic                           o_pixel_captured,
  output logic                           o_line_start,
  output logic                           o_line_end,
  output logic [LINE_COUNT_W-1:0]        o_line_count,
  output logic                           o_err_timeout,
  output logic                           o_err_length
);

  localparam int WW   = CHANNELS * DATA_WIDTH;
  localparam int PW   = cnt_width(LINE_PIXELS);
  localparam int TMAX = max_int(max_int(max_int(LOAD_CYCLES, RST_CVC_CYCLES),
                                        max_int(RST_CDS_CYCLES, SAMPLE_CYCLES)), ADC_TIMEOUT);
  localparam int TW   = cnt_width(TMAX);

  localparam logic [TW-1:0] LD_LOAD   = TW'(LOAD_CYCLES - 1);
  localparam logic [TW-1:0] LD_CVC    = TW'(RST_CVC_CYCLES - 1);
  localparam logic [TW-1:0] LD_CDS    = TW'(RST_CDS_CYCLES - 1);
  localparam logic [TW-1:0] LD_SAMPLE = TW'(SAMPLE_CYCLES - 1);
  localparam logic [TW-1:0] LD_ADC    = TW'(ADC_TIMEOUT - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(LINE_PIXELS - 1);
  localparam logic [PW-1:0] PIX_FULL  = PW'(LINE_PIXELS);

  ls_state_t               r_state;
  logic [PW-1:0]           r_pix_cnt;
  logic [WW-1:0]           r_pixel_data;
  logic                    r_pixel_captured;
  logic                    r_line_start;
  logic                    r_line_end_full;
  logic [LINE_COUNT_W-1:0] r_line_count;
  logic                    r_err_timeout;
  logic                    r_err_length;
  logic                    r_load_pulse;
  logic                    r_rst_cvc;
  logic                    r_rst_cds;
  logic                    r_sample;

  logic                    w_timer_load;
  logic [TW-1:0]           w_timer_value;
  logic                    w_timer_done;
  logic [WW-1:0]           w_word;

  linescanner_strobe_timer #(
    .WIDTH (TW)
  ) u_timer (
    .i_clk   (i_pixel_clock),
    .i_reset (i_reset),
    .i_load  (w_timer_load),
    .i_value (w_timer_value),
    .o_done  (w_timer_done)
  );

`ifdef LINESCANNER_TEST_PATTERN_EN
  // Synthetic lane words derived from the pixel counter.
  always_comb begin
    w_word = {WW{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      w_word[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(32'(r_pix_cnt) + 32'(k));
    end
  end
`else
  assign w_word = i_data;
`endif

  // Reload the shared timer on every transition into a timed state.
  always_comb begin
    w_timer_load  = 1'b0;
    w_timer_value = LD_LOAD;
    case (r_state)
      S_IDLE:    w_timer_load = i_enable;
      S_LOAD:    begin w_timer_load = w_timer_done; w_timer_value = LD_CVC;    end
      S_RST_CVC: begin w_timer_load = w_timer_done; w_timer_value = LD_CDS;    end
      S_RST_CDS: begin w_timer_load = w_timer_done; w_timer_value = LD_SAMPLE; end
      S_SAMPLE:  begin w_timer_load = w_timer_done; w_timer_value = LD_ADC;    end
      S_READOUT: w_timer_load = ~i_lval & i_enable;
      default:   begin w_timer_load = 1'b0; w_timer_value = LD_LOAD; end
    endcase
  end

  // Line sequencer with registered strobes, capture path, counters and sticky errors.
  always_ff @(posedge i_pixel_clock) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_pix_cnt        <= {PW{1'b0}};
      r_pixel_data     <= {WW{1'b0}};
      r_pixel_captured <= 1'b0;
      r_line_start     <= 1'b0;
      r_line_end_full  <= 1'b0;
      r_line_count     <= {LINE_COUNT_W{1'b0}};
      r_err_timeout    <= 1'b0;
      r_err_length     <= 1'b0;
      r_load_pulse     <= 1'b0;
      r_rst_cvc        <= 1'b0;
      r_rst_cds        <= 1'b0;
      r_sample         <= 1'b0;
    end else begin
      r_load_pulse     <= (r_state == S_LOAD);
      r_rst_cvc        <= (r_state == S_RST_CVC);
      r_rst_cds        <= (r_state == S_RST_CDS);
      r_sample         <= (r_state == S_SAMPLE);
      r_pixel_captured <= 1'b0;
      r_line_start     <= 1'b0;
      r_line_end_full  <= 1'b0;
      case (r_state)
        S_IDLE:    if (i_enable) r_state <= S_LOAD;
        S_LOAD:    if (w_timer_done) r_state <= S_RST_CVC;
        S_RST_CVC: if (w_timer_done) r_state <= S_RST_CDS;
        S_RST_CDS: if (w_timer_done) r_state <= S_SAMPLE;
        S_SAMPLE:  if (w_timer_done) r_state <= S_WAIT_ADC;
        S_WAIT_ADC: begin
          // end_adc is checked first so it wins against a simultaneous expiry.
          if (i_end_adc) begin
            r_state   <= S_WAIT_LVAL;
            r_pix_cnt <= {PW{1'b0}};
          end else if (w_timer_done) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_WAIT_LVAL, S_READOUT: begin
          if (i_lval) begin
            r_state <= S_READOUT;
            if (r_pix_cnt == PIX_FULL) begin
              r_err_length <= 1'b1;
            end else begin
              r_pixel_data     <= w_word;
              r_pixel_captured <= 1'b1;
              r_line_start     <= (r_pix_cnt == {PW{1'b0}});
              r_line_end_full  <= (r_pix_cnt == PIX_LAST);
              r_pix_cnt        <= r_pix_cnt + PW'(1);
            end
          end else if (r_state == S_READOUT) begin
            if (r_pix_cnt != PIX_FULL) r_err_length <= 1'b1;
            r_line_count <= r_line_count + LINE_COUNT_W'(1);
            r_state      <= i_enable ? S_LOAD : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_load_pulse     = r_load_pulse;
  assign o_rst_cvc        = r_rst_cvc;
  assign o_rst_cds        = r_rst_cds;
  assign o_sample         = r_sample;
  assign o_pixel_data     = r_pixel_data;
  assign o_pixel_captured = r_pixel_captured;
  assign o_line_start     = r_line_start;
  // A short line's end is only known when lval drops, one cycle after its last word
  // was registered, so that case is flagged from the live lval level.
  assign o_line_end       = r_line_end_full | (r_pixel_captured & ~i_lval);
  assign o_line_count     = r_line_count;
  assign o_err_timeout    = r_err_timeout;
  assign o_err_length     = r_err_length;

endmodule
